// File: rtl/pwm_timebase_if.sv
// Configuration handshake bundle for pwm_timebase: period/duty offered under valid/ready.
// A transfer happens on a rising clock edge where i_cfg_valid and o_cfg_ready are both high.
interface pwm_timebase_if #(
    parameter int WIDTH = 8
) ();
    logic             i_cfg_valid;
    logic             o_cfg_ready;
    logic [WIDTH-1:0] i_period;
    logic [WIDTH-1:0] i_duty;

    modport master (
        output i_cfg_valid,
        output i_period,
        output i_duty,
        input  o_cfg_ready
    );

    modport slave (
        input  i_cfg_valid,
        input  i_period,
        input  i_duty,
        output o_cfg_ready
    );
endinterface

// File: rtl/pwm_timebase.sv
// PWM counter and double-buffered period/duty shadow stage feeding an external greater-than comparator.
// Define PWM_CENTER_ALIGN_EN for an up/down (center-aligned) counter; default is edge-aligned up-count.
module pwm_timebase #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    pwm_timebase_if.slave    cfg_if,
    output logic [WIDTH-1:0] o_cmp_a,
    output logic [WIDTH-1:0] o_cmp_b,
    input  logic             i_gt,
    output logic             o_pwm,
    output logic             o_period_end
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] pend_period_q, pend_period_d;
    logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;
    logic             period_end_q, period_end_d;
    logic             wrap;
    logic             accept;
    logic             apply;

`ifdef PWM_CENTER_ALIGN_EN
    localparam logic [0:0] DIR_UP = 1'b0;
    localparam logic [0:0] DIR_DN = 1'b1;
    logic [0:0] dir_q, dir_d;
`endif

    // Counter: wrap is the boundary at which a pending update may take effect.
    always_comb begin
        wrap         = 1'b0;
        count_d      = '0;
        period_end_d = 1'b0;
        pwm_d        = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d        = DIR_UP;
`endif
        if (i_en) begin
            pwm_d = i_gt;
`ifdef PWM_CENTER_ALIGN_EN
            dir_d = dir_q;
            if (dir_q == DIR_UP) begin
                if (count_q == period_q) begin
                    // Periods of 0 or 1 have no down leg; they behave as a plain wrap.
                    if (period_q <= ONE) begin
                        wrap    = 1'b1;
                        count_d = '0;
                    end else begin
                        count_d = count_q - ONE;
                        dir_d   = DIR_DN;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
            end else if (count_q == ONE) begin
                wrap    = 1'b1;
                count_d = '0;
                dir_d   = DIR_UP;
            end else begin
                count_d = count_q - ONE;
            end
`else
            if (count_q == period_q) begin
                wrap    = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + ONE;
            end
`endif
            period_end_d = wrap;
        end
    end

    // Pending is only set when idle, so accept and apply never coincide on one edge.
    assign accept = cfg_if.i_cfg_valid & ~pending_q;
    assign apply  = pending_q & (wrap | ~i_en);

    always_comb begin
        period_d      = period_q;
        duty_d        = duty_q;
        pend_period_d = pend_period_q;
        pend_duty_d   = pend_duty_q;
        pending_d     = pending_q;
        if (apply) begin
            period_d  = pend_period_q;
            duty_d    = pend_duty_q;
            pending_d = 1'b0;
        end else if (accept) begin
            pend_period_d = cfg_if.i_period;
            pend_duty_d   = cfg_if.i_duty;
            pending_d     = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q       <= '0;
            period_q      <= '0;
            duty_q        <= '0;
            pend_period_q <= '0;
            pend_duty_q   <= '0;
            pending_q     <= 1'b0;
            pwm_q         <= 1'b0;
            period_end_q  <= 1'b0;
        end else begin
            count_q       <= count_d;
            period_q      <= period_d;
            duty_q        <= duty_d;
            pend_period_q <= pend_period_d;
            pend_duty_q   <= pend_duty_d;
            pending_q     <= pending_d;
            pwm_q         <= pwm_d;
            period_end_q  <= period_end_d;
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dir_q <= DIR_UP;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    assign cfg_if.o_cfg_ready = ~pending_q;
    assign o_cmp_a            = duty_q;
    assign o_cmp_b            = count_q;
    assign o_pwm              = pwm_q;
    assign o_period_end       = period_end_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Directed bench for pwm_timebase with a behavioural comparator and a scoreboard of per-cycle outputs.
// Expected vector layout: {cfg_ready, period_end, pwm, cmp_a, cmp_b}.
module tb_pwm_timebase;
    localparam int W  = 8;
    localparam int VW = 2 * W + 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         gt;
    logic [W-1:0] cmp_a, cmp_b;
    logic         pwm, pe;

    pwm_timebase_if #(.WIDTH(W)) cfg_if ();

    pwm_timebase #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .cfg_if       (cfg_if),
        .o_cmp_a      (cmp_a),
        .o_cmp_b      (cmp_b),
        .i_gt         (gt),
        .o_pwm        (pwm),
        .o_period_end (pe)
    );

    always #5 clk = ~clk;

    // Downstream greater-than comparator.
    assign gt = (cmp_a > cmp_b);

    logic [VW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int win_pe  = 0;
    int win_hi  = 0;

    logic [W-1:0] m_cnt, m_per, m_duty, m_pper, m_pduty;
    logic         m_pend, m_dir;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = '0; m_per = '0; m_duty = '0; m_pper = '0; m_pduty = '0;
        m_pend = 1'b0; m_dir = 1'b0;
        exp_q.delete();
    endtask

    // Drive inputs for the next edge and push what the outputs must be after it.
    task automatic drive(input logic v_en, input logic v_valid,
                         input logic [W-1:0] v_per, input logic [W-1:0] v_duty);
        logic         wrap_m, n_pe, n_pwm, n_dir;
        logic [W-1:0] n_cnt;
        en                 = v_en;
        cfg_if.i_cfg_valid = v_valid;
        cfg_if.i_period    = v_per;
        cfg_if.i_duty      = v_duty;
        wrap_m = 1'b0;
        n_cnt  = '0;
        n_dir  = v_en ? m_dir : 1'b0;
        n_pwm  = v_en && (m_duty > m_cnt);
        if (v_en) begin
`ifdef PWM_CENTER_ALIGN_EN
            if (!m_dir) begin
                if (m_cnt == m_per) begin
                    if (m_per < 2) begin wrap_m = 1'b1; n_cnt = '0; end
                    else begin n_cnt = W'(m_cnt - 1); n_dir = 1'b1; end
                end else n_cnt = W'(m_cnt + 1);
            end else begin
                n_cnt = W'(m_cnt - 1);
                if (m_cnt == 1) begin wrap_m = 1'b1; n_dir = 1'b0; end
            end
`else
            wrap_m = (m_cnt == m_per);
            n_cnt  = wrap_m ? '0 : W'(m_cnt + 1);
`endif
        end
        n_pe = v_en && wrap_m;
        if (m_pend && (wrap_m || !v_en)) begin
            m_per  = m_pper;
            m_duty = m_pduty;
            m_pend = 1'b0;
        end else if (v_valid && !m_pend) begin
            m_pper  = v_per;
            m_pduty = v_duty;
            m_pend  = 1'b1;
        end
        m_cnt = n_cnt;
        m_dir = n_dir;
        exp_q.push_back({!m_pend, n_pe, n_pwm, m_duty, m_cnt});
    endtask

    task automatic tick(input string tag);
        logic [VW-1:0] exp_v;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            exp_v = exp_q.pop_front();
            check(tag, 32'({cfg_if.o_cfg_ready, pe, pwm, cmp_a, cmp_b}), 32'(exp_v));
        end
        win_pe += int'(pe);
        win_hi += int'(pwm);
    endtask

    task automatic step(input logic v_en, input logic v_valid,
                        input logic [W-1:0] v_per, input logic [W-1:0] v_duty, input string tag);
        drive(v_en, v_valid, v_per, v_duty);
        tick(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'd0, 8'd0, tag);
    endtask

    task automatic run_to(input logic [W-1:0] c, input string tag);
        for (int i = 0; i < 64 && m_cnt != c; i++) step(1'b1, 1'b0, 8'd0, 8'd0, tag);
    endtask

    task automatic load(input logic [W-1:0] p, input logic [W-1:0] d, input string tag);
        step(1'b1, 1'b1, p, d, tag);
        for (int i = 0; i < 64 && m_pend; i++) step(1'b1, 1'b0, 8'd0, 8'd0, tag);
    endtask

    task automatic window(input int n, input int exp_pe, input int exp_hi, input string tag);
        win_pe = 0;
        win_hi = 0;
        run(n, tag);
        check({tag, "_pulses"}, 32'(win_pe), 32'(exp_pe));
        check({tag, "_high"}, 32'(win_hi), 32'(exp_hi));
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check(tag, 32'({cfg_if.o_cfg_ready, pe, pwm, cmp_a, cmp_b}), 32'({1'b1, 1'b0, 1'b0, 8'd0, 8'd0}));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        cfg_if.i_cfg_valid = 1'b0;
        cfg_if.i_period    = '0;
        cfg_if.i_duty      = '0;
        model_reset();
        #2;
        check("reset_vals", 32'({cfg_if.o_cfg_ready, pe, pwm, cmp_a, cmp_b}), 32'({1'b1, 1'b0, 1'b0, 8'd0, 8'd0}));
        @(negedge clk);
        rst_n = 1'b1;

`ifndef PWM_CENTER_ALIGN_EN
        step(1'b1, 1'b1, 8'd9, 8'd3, "load_accept");
        check("ready_low_after_accept", 32'(cfg_if.o_cfg_ready), 32'd0);
        step(1'b1, 1'b0, 8'd0, 8'd0, "load_apply");
        check("ready_high_after_apply", 32'(cfg_if.o_cfg_ready), 32'd1);
        run(5, "run_p9d3");
        window(20, 2, 6, "win_p9d3");

        run_to(8'd4, "seek_mid");
        step(1'b1, 1'b1, 8'd4, 8'd2, "upd_accept");
        check("upd_ready_low", 32'(cfg_if.o_cfg_ready), 32'd0);
        step(1'b1, 1'b1, 8'd7, 8'd7, "upd_second_valid");
        check("upd_second_ignored", 32'(cfg_if.o_cfg_ready), 32'd0);
        check("upd_old_duty_held", 32'(cmp_a), 32'd3);
        run_to(8'd0, "upd_to_wrap");
        check("upd_new_duty", 32'(cmp_a), 32'd2);
        run(5, "run_p4d2");
        window(10, 2, 4, "win_p4d2");

        load(8'd9, 8'd0, "load_d0");
        run(5, "run_d0");
        window(20, 2, 0, "win_d0");
        load(8'd9, 8'd10, "load_d10");
        run(5, "run_d10");
        window(20, 2, 20, "win_d10");
        load(8'd0, 8'd0, "load_p0");
        run(3, "run_p0");
        window(20, 20, 0, "win_p0");

        load(8'd9, 8'd3, "load_en");
        run(3, "run_en");
        run_to(8'd4, "seek_en");
        step(1'b1, 1'b1, 8'd6, 8'd4, "en_upd_accept");
        check("en_count5", 32'(cmp_b), 32'd5);
        step(1'b0, 1'b0, 8'd0, 8'd0, "en_drop");
        check("en_drop_state", 32'({cfg_if.o_cfg_ready, pwm, cmp_a, cmp_b}), 32'({1'b1, 1'b0, 8'd4, 8'd0}));
        step(1'b0, 1'b0, 8'd0, 8'd0, "en_idle");
        step(1'b1, 1'b0, 8'd0, 8'd0, "en_raise");
        check("en_restart_count", 32'(cmp_b), 32'd1);
        run(5, "run_p6d4");
        window(14, 2, 8, "win_p6d4");

        run_to(8'd2, "seek_rst");
        step(1'b1, 1'b1, 8'd9, 8'd9, "rst_pend_accept");
        async_reset_check("async_reset");
        run(12, "post_reset");
        check("post_reset_pending_gone", 32'({cfg_if.o_cfg_ready, cmp_a}), 32'({1'b1, 8'd0}));
`else
        load(8'd4, 8'd2, "c_load");
        run(8, "c_run");
        window(16, 2, 6, "c_win_p4d2");
        run_to(8'd0, "c_seek_bottom");
        check("c_bottom_count", 32'(cmp_b), 32'd0);
        load(8'd1, 8'd1, "c_load_p1");
        run(4, "c_run_p1");
        window(8, 4, 4, "c_win_p1");
        load(8'd0, 8'd0, "c_load_p0");
        run(3, "c_run_p0");
        window(8, 8, 0, "c_win_p0");
        load(8'd4, 8'd2, "c_reload");
        run_to(8'd3, "c_seek_rst");
        step(1'b1, 1'b1, 8'd6, 8'd6, "c_rst_pend_accept");
        async_reset_check("c_async_reset");
        run(10, "c_post_reset");
        check("c_post_reset_pending_gone", 32'({cfg_if.o_cfg_ready, cmp_a}), 32'({1'b1, 8'd0}));
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_timebase.md
Name: pwm_timebase

Overview:
- Counter and shadow-register stage that sits directly upstream of the greater-than comparator in the waveform generator.
- Drives the comparator operands with the active duty value and the running count.
- Registers the comparator's o_gt result back in as the PWM output.
- Period and duty updates are double-buffered through a valid/ready handshake and take effect only at period boundaries, so there are no glitches.

Parameters:
- WIDTH, 8, width of count, period and duty values; must match the comparator WIDTH.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  count enable; low holds the timebase idle.
- i_cfg_valid  input  1  new period/duty offered.
- o_cfg_ready  output  1  block can accept a new period/duty.
- i_period  input  WIDTH  period value; counter runs 0..i_period, giving i_period+1 cycles.
- i_duty  input  WIDTH  duty threshold; output is high while duty > count.
- o_cmp_a  output  WIDTH  active duty; drives comparator i_a.
- o_cmp_b  output  WIDTH  current count; drives comparator i_b.
- i_gt  input  1  comparator o_gt, combinational from o_cmp_a/o_cmp_b.
- o_pwm  output  1  registered i_gt, gated by enable.
- o_period_end  output  1  one-cycle pulse on the cycle count wraps.

Behaviour:
- Reset (async assert, sync release): count=0, period_act=0, duty_act=0, pending=0, o_cfg_ready=1, o_pwm=0, o_period_end=0.
- Handshake:
  - A transfer occurs on a rising edge with i_cfg_valid & o_cfg_ready.
  - i_period/i_duty are captured into pending registers and o_cfg_ready drops the next cycle.
  - While pending, i_cfg_valid is ignored and the pending values are not overwritten.
- Apply pending:
  - Pending values copy to period_act/duty_act on the wrap edge (count==period_act with i_en=1), or on any edge with i_en=0.
  - o_cfg_ready returns high the cycle after apply.
  - If a transfer and an apply condition fall on the same edge, the new values are captured into pending and apply at the next boundary; they are never applied in the same edge they are accepted.
- Counting when i_en=1:
  - If count==period_act: count<=0 and o_period_end<=1.
  - Otherwise: count<=count+1 and o_period_end<=0.
  - Count never exceeds period_act, because a period change applies only at a wrap.
  - period_act=0 gives count constantly 0 and o_period_end high every cycle.
- When i_en=0: count<=0, o_period_end<=0, o_pwm<=0, pending applied as above.
- Output:
  - o_cmp_a=duty_act and o_cmp_b=count, both directly from registers.
  - o_pwm<=i_gt & i_en. o_pwm lags o_cmp_b by 1 cycle.
- Duty boundaries:
  - duty_act=0 gives o_pwm always 0.
  - duty_act>period_act gives o_pwm always 1 (100%).
  - Otherwise high-time = duty_act cycles per period_act+1 cycles.
- Arithmetic: unsigned, WIDTH bits, no saturation needed since the wrap compare precedes the increment.
- Reset mid-period: all state clears immediately; a pending update is discarded.

Optional Feature:
- Macro: PWM_CENTER_ALIGN_EN.
- Defined: the counter counts up 0..period_act, then down period_act-1..1, then repeats.
  - Direction flag resets to up.
  - o_period_end pulses when count reaches 0 at the bottom.
  - Pending apply happens at the bottom only.
  - Period = 2*period_act cycles; period_act=0 behaves as in edge mode.
  - Output is symmetric about the peak.
- Undefined: edge-aligned up-count only; no direction register is present.

Test Plan:
- Reset, then load period=9, duty=3 with en=1 -> o_cfg_ready low 1 cycle after accept, then high after first wrap. o_period_end every 10 cycles. o_pwm high 3 of 10 cycles, 1 cycle after count 0..2.
- While running period=9 duty=3, offer period=4 duty=2 mid-period -> old values held until count=9 wraps. Next period is 5 cycles with 2 high. A second valid while pending is not accepted (o_cfg_ready=0).
- Boundary duties: duty=0 -> o_pwm constant 0. duty=10 with period=9 -> o_pwm constant 1. period=0 -> o_period_end high every cycle, count stays 0.
- Drop en mid-period at count=5 -> count=0, o_pwm=0 next cycle, pending update applied while disabled. Raise en -> count restarts from 0 with new values.
- Assert i_rst_n=0 asynchronously mid-count with an update pending -> all outputs at reset values without a clock edge. After release, old pending values are gone and o_cfg_ready=1.
- PWM_CENTER_ALIGN_EN defined, period=4 duty=2 -> count sequence 0,1,2,3,4,3,2,1,0,... o_pwm high while count<2, delayed 1 cycle. o_period_end pulses only at the bottom every 8 cycles.
